// File: rtl/freq_bcd_disp_if.sv
// Frequency result bus between the FFT control stage (master) and the BCD display block (slave).
interface freq_bcd_disp_if;
    logic [15:0] wave_freq;
    logic        freq_vaild;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic        busy;

    modport master (
        output wave_freq,
        output freq_vaild,
        input  bcd,
        input  bcd_valid,
        input  busy
    );

    modport slave (
        input  wave_freq,
        input  freq_vaild,
        output bcd,
        output bcd_valid,
        output busy
    );
endinterface

// File: rtl/freq_bcd_disp.sv
// Latches a 16-bit frequency, converts it to 5-digit BCD by serial double-dabble,
// and scans the last result onto a 5-digit common-anode 7-segment display.
module freq_bcd_disp #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          BLANK_LEAD = 1'b1
) (
    input  logic             clk_50m,
    input  logic             rst,
    freq_bcd_disp_if.slave   bus,
    output logic [7:0]       seg,
    output logic [4:0]       sel
);
    localparam int unsigned BIN_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned DIG_N  = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BIN_W-1:0]    r_sh_bin;
    logic [BCD_W-1:0]    r_sh_bcd;
    logic [CNT_W-1:0]    r_sh_cnt;
    logic                r_pending;
    logic [BIN_W-1:0]    r_pend_val;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_bcd_valid;
    logic                r_busy;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4:0]          r_sel;
    logic [7:0]          r_seg;

    logic                w_start;
    logic [BIN_W-1:0]    w_src;
    logic [BCD_W-1:0]    w_adj;
    logic [BIN_W+BCD_W-1:0] w_shl;
    logic                w_wrap;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [3:0]          w_dig;
    logic [DIG_N-1:0]    w_blank;
    logic [7:0]          w_seg_nxt;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk_50m) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.freq_vaild || r_pending) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_sh_cnt == CNT_W'(15))     w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Conversion controls: a fresh request beats the stored one
    always_comb begin
        w_start = (r_state == ST_IDLE) && (bus.freq_vaild || r_pending);
        w_src   = bus.freq_vaild ? bus.wave_freq : r_pend_val;
        w_adj   = r_sh_bcd;
        for (int i = 0; i < int'(DIG_N); i++) begin
            if (r_sh_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_sh_bcd[4*i +: 4] + 4'd3;
        end
        w_shl = {w_adj, r_sh_bin} << 1;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_sh_bin    <= '0;
            r_sh_bcd    <= '0;
            r_sh_cnt    <= '0;
            r_pending   <= 1'b0;
            r_pend_val  <= '0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            r_busy      <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sh_bin  <= w_src;
                        r_sh_bcd  <= '0;
                        r_sh_cnt  <= '0;
                        r_pending <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    {r_sh_bcd, r_sh_bin} <= w_shl;
                    r_sh_cnt             <= CNT_W'(r_sh_cnt + 1'b1);
                end
                ST_DONE: begin
                    r_bcd       <= r_sh_bcd;
                    r_bcd_valid <= 1'b1;
                end
                default: ;
            endcase
            if ((r_state != ST_IDLE) && bus.freq_vaild) begin
                r_pending  <= 1'b1;
                r_pend_val <= bus.wave_freq;
            end
        end
    end

    // Digit scan and segment decode from the registered result
    always_comb begin
        w_wrap    = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
        w_idx_nxt = r_idx;
        if (w_wrap) w_idx_nxt = (r_idx == IDX_W'(DIG_N - 1)) ? '0 : IDX_W'(r_idx + 1'b1);
        w_blank    = '0;
        w_blank[4] = BLANK_LEAD && (r_bcd[19:16] == 4'd0);
        w_blank[3] = w_blank[4] && (r_bcd[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
        case (w_idx_nxt)
            3'd1:    w_dig = r_bcd[7:4];
            3'd2:    w_dig = r_bcd[11:8];
            3'd3:    w_dig = r_bcd[15:12];
            3'd4:    w_dig = r_bcd[19:16];
            default: w_dig = r_bcd[3:0];
        endcase
        w_seg_nxt = w_blank[w_idx_nxt] ? 8'hFF : seg_decode(w_dig);
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_sel      <= 5'b11110;
            r_seg      <= 8'hC0;
        end else begin
            r_scan_cnt <= w_wrap ? '0 : SCAN_W'(r_scan_cnt + 1'b1);
            r_idx      <= w_idx_nxt;
            r_sel      <= ~(5'(5'b00001 << w_idx_nxt));
            r_seg      <= w_seg_nxt;
        end
    end

    assign bus.bcd       = r_bcd;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.busy      = r_busy;
    assign seg           = r_seg;
    assign sel           = r_sel;

endmodule

// File: tb/tb_freq_bcd_disp.sv
// Directed bench for freq_bcd_disp: conversion latency, overlap, blanking, scan and reset abort.
module tb_freq_bcd_disp;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_a, seg_b;
    logic [4:0] sel_a, sel_b;
    int         n_checks = 0;
    int         n_errors = 0;

    freq_bcd_disp_if bus_a ();
    freq_bcd_disp_if bus_b ();

    freq_bcd_disp #(.SCAN_DIV(4), .BLANK_LEAD(1'b1)) dut_a (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus_a),
        .seg     (seg_a),
        .sel     (sel_a)
    );

    freq_bcd_disp #(.SCAN_DIV(4), .BLANK_LEAD(1'b0)) dut_b (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus_b),
        .seg     (seg_b),
        .sel     (sel_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [15:0] v);
        @(negedge clk);
        bus_a.wave_freq  = v;
        bus_a.freq_vaild = 1'b1;
        @(negedge clk);
        bus_a.freq_vaild = 1'b0;
    endtask

    // Run to the result edge (k+17) and check the pulse and value
    task automatic convert_check(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd);
        pulse(v);
        check({tag, "_busy"}, 32'(bus_a.busy), 32'd1);
        repeat (16) @(negedge clk);
        check({tag, "_early_valid"}, 32'(bus_a.bcd_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus_a.bcd_valid), 32'd1);
        check({tag, "_bcd"}, 32'(bus_a.bcd), 32'(exp_bcd));
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus_a.bcd_valid), 32'd0);
    endtask

    task automatic seg_at(input string tag, input int idx, input logic [7:0] exp_seg);
        logic [4:0] exp_sel;
        int n;
        exp_sel = ~(5'(5'b00001 << idx));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sel_a !== exp_sel && n < 20);
        check({tag, "_sel"}, 32'(sel_a), 32'(exp_sel));
        check({tag, "_seg"}, 32'(seg_a), 32'(exp_seg));
    endtask

    initial begin
        logic [4:0] prev;
        logic [4:0] exp_seq [5];
        int         gap;
        int         n_valid;
        int         t_first, t_second;
        logic [19:0] b_first, b_second;
        logic        busy_t18;

        exp_seq[0] = 5'b11101; exp_seq[1] = 5'b11011; exp_seq[2] = 5'b10111;
        exp_seq[3] = 5'b01111; exp_seq[4] = 5'b11110;

        rst = 1'b1;
        bus_a.wave_freq = '0; bus_a.freq_vaild = 1'b0;
        bus_b.wave_freq = '0; bus_b.freq_vaild = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_sel", 32'(sel_a), 32'h1E);
        check("rst_seg", 32'(seg_a), 32'hC0);
        check("rst_bcd", 32'(bus_a.bcd), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_valid", 32'(bus_a.bcd_valid), 32'd0);

        // Scan order and period, no blanking
        prev = sel_b;
        for (int s = 0; s < 5; s++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (sel_b === prev && gap < 10);
            check($sformatf("scan_gap%0d", s), 32'(gap), 32'd4);
            check($sformatf("scan_sel%0d", s), 32'(sel_b), 32'(exp_seq[s]));
            check($sformatf("scan_seg%0d", s), 32'(seg_b), 32'hC0);
            prev = sel_b;
        end

        // 5000 and its display
        convert_check("c5000", 16'd5000, 20'h05000);
        seg_at("d5000_0", 0, 8'hC0);
        seg_at("d5000_1", 1, 8'hC0);
        seg_at("d5000_2", 2, 8'hC0);
        seg_at("d5000_3", 3, 8'h92);
        seg_at("d5000_4", 4, 8'hFF);

        // Extremes
        convert_check("c65535", 16'd65535, 20'h65535);
        seg_at("d65535_4", 4, 8'h82);
        seg_at("d65535_0", 0, 8'h92);
        convert_check("c0", 16'd0, 20'h00000);
        seg_at("d0_0", 0, 8'hC0);
        seg_at("d0_1", 1, 8'hFF);
        seg_at("d0_2", 2, 8'hFF);
        seg_at("d0_3", 3, 8'hFF);
        seg_at("d0_4", 4, 8'hFF);
        convert_check("c9999", 16'd9999, 20'h09999);

        // Overlap: newest pending value wins
        pulse(16'd1234);
        n_valid = 0; t_first = -1; t_second = -1; b_first = '0; b_second = '0; busy_t18 = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus_a.bcd_valid) begin
                n_valid++;
                if (n_valid == 1) begin t_first = t; b_first = bus_a.bcd; end
                else if (n_valid == 2) begin t_second = t; b_second = bus_a.bcd; end
            end
            if (t == 18) busy_t18 = bus_a.busy;
            if (t == 3)  begin bus_a.wave_freq = 16'd4321; bus_a.freq_vaild = 1'b1; end
            if (t == 4)  bus_a.freq_vaild = 1'b0;
            if (t == 9)  begin bus_a.wave_freq = 16'd777;  bus_a.freq_vaild = 1'b1; end
            if (t == 10) bus_a.freq_vaild = 1'b0;
        end
        check("ovl_pulses", 32'(n_valid), 32'd2);
        check("ovl_t1", 32'(t_first), 32'd17);
        check("ovl_bcd1", 32'(b_first), 32'h01234);
        check("ovl_t2", 32'(t_second), 32'd35);
        check("ovl_bcd2", 32'(b_second), 32'h00777);
        check("ovl_busy18", 32'(busy_t18), 32'd1);

        // Reset mid-conversion with a pending request
        pulse(16'd4444);
        n_valid = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus_a.bcd_valid) n_valid++;
            if (t == 8) begin
                check("abort_busy", 32'(bus_a.busy), 32'd0);
                check("abort_bcd", 32'(bus_a.bcd), 32'd0);
                rst = 1'b0;
            end
            if (t == 3) begin bus_a.wave_freq = 16'd999; bus_a.freq_vaild = 1'b1; end
            if (t == 4) bus_a.freq_vaild = 1'b0;
            if (t == 7) rst = 1'b1;
        end
        check("abort_no_valid", 32'(n_valid), 32'd0);
        check("abort_idle", 32'(bus_a.busy), 32'd0);
        check("abort_bcd_end", 32'(bus_a.bcd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
